mux_scan_ctrl: RTL and testbench

Sequencer for the 10:1 select mux and 8-LED display path. On a start pulse it steps the mux select through the enabled input channels, holding each for a programmable dwell so the mux output settles, and samples the mux output into a 10-bit result register. It drives `led` with scan progress while busy and with the result when idle. It sits beside the mux and LED blocks under the top level and owns their `sel` input and LED bus.

---
 rtl/mux_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mux_scan_ctrl
// Description : Scan sequencer for the 10:1 select mux and the 8-LED display.
//               It steps sel through the enabled channels and holds each one
//               for DWELL cycles so the mux output can settle. At the end of
//               the hold it captures y_in into sample. led shows scan progress
//               while busy and shows the result when idle.
//               Optional: `define MUX_SCAN_CONTINUOUS_EN to restart a new scan
//               straight from DONE while start is held high.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_ctrl #(
  parameter int NUM_CH = 10,
  parameter int DWELL  = 4,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] en_mask,
  input  logic              y_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] sample,
  output logic              busy,
  output logic              done,
  output logic [7:0]        led
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] C_LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_last_ch;
  logic              w_ch_en;
  logic              w_ch_end;
  logic [15:0]       w_sel_pad;
  logic [15:0]       w_sample_pad;

  // The current channel is finished after a one-cycle skip when it is
  // disabled. When it is enabled, it is finished on the last dwell cycle.
  assign w_last_ch    = (sel == C_LAST_SEL);
  assign w_ch_en      = r_mask[sel];
  assign w_ch_end     = !w_ch_en || (r_cnt == C_CNT_LAST);
  assign w_sel_pad    = 16'(sel);
  assign w_sample_pad = 16'(sample);

  // Scan state machine: mask latch, channel stepping, dwell count and capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      sel     <= '0;
      sample  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= S_SCAN;
            r_mask  <= en_mask;
            sel     <= '0;
            r_cnt   <= '0;
            sample  <= '0;
            busy    <= 1'b1;
          end
        end

        S_SCAN: begin
          if (w_ch_end) begin
            if (w_ch_en) begin
              sample[sel] <= y_in;
            end
            r_cnt <= '0;
            if (w_last_ch) begin
              // sel returns to 0 here, so it never takes the value NUM_CH.
              r_state <= S_DONE;
              sel     <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              sel <= sel + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          done <= 1'b0;
          sel  <= '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
          // Back-to-back scan. sample is kept and each bit is overwritten
          // when its channel is captured again.
          if (start) begin
            r_state <= S_SCAN;
            r_mask  <= en_mask;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // LED bus is built from registered state. It shows a one-hot position while
  // busy (channels 8 and 9 wrap onto LEDs 0 and 1) and the result otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (busy) begin
      led <= 8'b1 << w_sel_pad[2:0];
    end else begin
      led <= w_sample_pad[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl. The expected sel
//               sequence is built as a queue from the enable mask. The
//               expected result is computed as mask & y pattern.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int NUM_CH = 10;
  localparam int DWELL  = 4;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NUM_CH-1:0] en_mask;
  logic [NUM_CH-1:0] ypat;
  logic              y_in;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] sample;
  logic              busy;
  logic              done;
  logic [7:0]        led;

  int n_checks = 0;
  int n_fail   = 0;

  mux_scan_ctrl #(.NUM_CH(NUM_CH), .DWELL(DWELL), .SEL_W(SEL_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en_mask (en_mask),
    .y_in    (y_in),
    .sel     (sel),
    .sample  (sample),
    .busy    (busy),
    .done    (done),
    .led     (led)
  );

  always #5 clk = ~clk;

  // Mux model: Y follows sel combinationally.
  assign y_in = (int'(sel) < NUM_CH) ? ypat[sel] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one scan, checks every busy cycle against the reference queue, and
  // then checks the done pulse, the result and the idle LED value.
  task automatic run_scan(input logic [NUM_CH-1:0] m, input logic [NUM_CH-1:0] p,
                          input bit disturb, input string tag);
    int q[$];
    logic [NUM_CH-1:0] exp_s;
    logic [7:0] exp_led;
    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < (m[c] ? DWELL : 1); r++) q.push_back(c);
    exp_s = m & p;
    ypat    = p;
    en_mask = m;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_sel"}, 32'(sel), 32'(q[i]));
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      if (i > 0) begin
        exp_led = 8'd1 << (q[i-1] % 8);
        chk({tag, "_led_busy"}, 32'(led), 32'(exp_led));
      end
      if (disturb && i == 5) begin
        start   = 1'b1;
        en_mask = ~m;
      end
      if (disturb && i == 6) start = 1'b0;
      step();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_sel_zero"}, 32'(sel), 32'd0);
    chk({tag, "_sample"}, 32'(sample), 32'(exp_s));
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_led_idle"}, 32'(led), 32'(exp_s[7:0]));
    chk({tag, "_hold"}, 32'(sample), 32'(exp_s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    bit saw_busy;
    rst     = 1'b1;
    start   = 1'b0;
    en_mask = '0;
    ypat    = '0;
    repeat (2) step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst = 1'b0;
    step();

    // Full mask, alternating Y: result 0x2AA, LEDs 0xAA.
    run_scan(10'h3FF, 10'h2AA, 1'b0, "full");
    // Sparse mask, Y all ones.
    run_scan(10'b0000100101, 10'h3FF, 1'b0, "sparse");
    // Empty mask: ten one-cycle skips, sample stays 0.
    run_scan(10'h000, 10'h3FF, 1'b0, "empty");
    // Start pulse and mask change in mid-scan are ignored.
    run_scan(10'h1C3, 10'h155, 1'b1, "ignore");
    // Random masks and patterns.
    for (int n = 0; n < 6; n++)
      run_scan(NUM_CH'($urandom), NUM_CH'($urandom), n[0], "rand");

    // Abort: reset in cycle 15 of a full scan.
    ypat    = 10'h3FF;
    en_mask = 10'h3FF;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_sample", 32'(sample), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_led", 32'(led), 32'd0);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (done) saw_done = 1'b1;
      if (busy) saw_busy = 1'b1;
      step();
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_stays_idle", 32'(saw_busy), 32'd0);

    // Start held high through the end of a scan.
    ypat    = 10'h0F0;
    en_mask = 10'h3FF;
    start   = 1'b1;
    step();
    for (int i = 0; i < NUM_CH * DWELL; i++) begin
      chk("hold_busy", 32'(busy), 32'd1);
      step();
    end
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_done_busy", 32'(busy), 32'd0);
    step();
`ifdef MUX_SCAN_CONTINUOUS_EN
    chk("cont_restart_busy", 32'(busy), 32'd1);
    chk("cont_restart_sel", 32'(sel), 32'd0);
    chk("cont_restart_done", 32'(done), 32'd0);
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 60 && !saw_done; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    chk("cont_second_done", 32'(saw_done), 32'd1);
    chk("cont_second_sample", 32'(sample), 32'(10'h0F0));
    step();
`else
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_done", 32'(done), 32'd0);
    start = 1'b0;
    step();
    chk("single_stays_idle", 32'(busy), 32'd0);
`endif
    step();
    chk("hold_sample", 32'(sample), 32'(10'h0F0));
    chk("hold_led", 32'(led), 32'h0F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
